// File: rtl/seg7_pattern_decoder.sv
// seg7_pattern_decoder: glitch-filtered decoder turning two FGABPCDE segment buses back into hex digits.
// Build option SEG7DEC_ERRCNT_EN adds the ERRCNT port with a saturating invalid-accept counter.
module seg7_pattern_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       CLK20MHz,
  input  logic       RESET,
  input  logic [7:0] SEG1,
  input  logic [7:0] SEG0,
  output logic [7:0] VALUE,
  output logic       DP1,
  output logic       DP0,
  output logic       UPDATE,
  output logic       ERROR
`ifdef SEG7DEC_ERRCNT_EN
  ,
  output logic [7:0] ERRCNT
`endif
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_SAT = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ACC = CW'(STABLE_CYCLES - 1);

  // Returns {valid, nibble}; the P bit is ignored so a lit decimal point never breaks decoding.
  function automatic logic [4:0] decode(input logic [7:0] seg);
    logic [4:0] r;
    case (seg & 8'hf7)
      8'hb7:   r = 5'h10;
      8'h14:   r = 5'h11;
      8'h73:   r = 5'h12;
      8'h76:   r = 5'h13;
      8'hd4:   r = 5'h14;
      8'he6:   r = 5'h15;
      8'he7:   r = 5'h16;
      8'hb4:   r = 5'h17;
      8'hf7:   r = 5'h18;
      8'hf6:   r = 5'h19;
      8'hf5:   r = 5'h1a;
      8'hc7:   r = 5'h1b;
      8'ha3:   r = 5'h1c;
      8'h57:   r = 5'h1d;
      8'he3:   r = 5'h1e;
      8'he1:   r = 5'h1f;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  logic [15:0]   cur;
  logic [15:0]   samp;
  logic [CW-1:0] cnt;
  logic          have;
  logic          accept;
  logic [4:0]    dec1;
  logic [4:0]    dec0;
  logic [7:0]    next_value;

  assign cur        = {SEG1, SEG0};
  assign accept     = (cur == samp) && (cnt == CNT_ACC);
  assign dec1       = decode(SEG1);
  assign dec0       = decode(SEG0);
  assign next_value = {dec1[3:0], dec0[3:0]};

  always_ff @(posedge CLK20MHz) begin
    if (RESET) begin
      samp   <= '0;
      cnt    <= '0;
      VALUE  <= '0;
      DP1    <= 1'b0;
      DP0    <= 1'b0;
      UPDATE <= 1'b0;
      ERROR  <= 1'b0;
      have   <= 1'b0;
`ifdef SEG7DEC_ERRCNT_EN
      ERRCNT <= '0;
`endif
    end else begin
      samp   <= cur;
      UPDATE <= 1'b0;
      if (cur != samp)
        cnt <= '0;
      else if (cnt != CNT_SAT)
        cnt <= cnt + CW'(1);

      if (accept) begin
        if (dec1[4] && dec0[4]) begin
          VALUE  <= next_value;
          DP1    <= SEG1[3];
          DP0    <= SEG0[3];
          ERROR  <= 1'b0;
          UPDATE <= (next_value != VALUE) || !have;
          have   <= 1'b1;
        end else begin
          ERROR <= 1'b1;
`ifdef SEG7DEC_ERRCNT_EN
          if (ERRCNT != 8'hff)
            ERRCNT <= ERRCNT + 8'd1;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_pattern_decoder.sv
// Bench for seg7_pattern_decoder: table vectors through a scoreboard queue on a 4-cycle and a
// 1-cycle filter instance, plus hand sequences for glitches, reset timing and counter saturation.
module tb_seg7_pattern_decoder;

  typedef struct {
    logic [7:0] s1;
    logic [7:0] s0;
    logic [7:0] val;
    logic       dp1;
    logic       dp0;
    logic       err;
    logic       upd;
    logic [7:0] ec;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst4, rst1;
  logic [7:0] seg1a, seg0a, seg1b, seg0b;
  logic [7:0] val4, val1;
  logic       dp14, dp04, upd4, err4;
  logic       dp11, dp01, upd1, err1;
  logic [7:0] ec4, ec1;

  int n_assert = 0;
  int n_fail   = 0;
  vec_t sb[$];
  vec_t tbl[11];

  always #25 clk = ~clk;

  seg7_pattern_decoder #(.STABLE_CYCLES(4)) u4 (
    .CLK20MHz(clk), .RESET(rst4), .SEG1(seg1a), .SEG0(seg0a),
    .VALUE(val4), .DP1(dp14), .DP0(dp04), .UPDATE(upd4), .ERROR(err4)
`ifdef SEG7DEC_ERRCNT_EN
    , .ERRCNT(ec4)
`endif
  );

  seg7_pattern_decoder #(.STABLE_CYCLES(1)) u1 (
    .CLK20MHz(clk), .RESET(rst1), .SEG1(seg1b), .SEG0(seg0b),
    .VALUE(val1), .DP1(dp11), .DP0(dp01), .UPDATE(upd1), .ERROR(err1)
`ifdef SEG7DEC_ERRCNT_EN
    , .ERRCNT(ec1)
`endif
  );

`ifndef SEG7DEC_ERRCNT_EN
  assign ec4 = 8'h00;
  assign ec1 = 8'h00;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cmp_vec(input string tag, input vec_t e, input logic [7:0] v, input logic d1,
                         input logic d0, input logic er, input logic up, input logic [7:0] ec);
    chk({tag, ".value"}, 32'(v), 32'(e.val));
    chk({tag, ".dp1"}, 32'(d1), 32'(e.dp1));
    chk({tag, ".dp0"}, 32'(d0), 32'(e.dp0));
    chk({tag, ".error"}, 32'(er), 32'(e.err));
    chk({tag, ".update"}, 32'(up), 32'(e.upd));
`ifdef SEG7DEC_ERRCNT_EN
    chk({tag, ".errcnt"}, 32'(ec), 32'(e.ec));
`endif
  endtask

  // Called at a negedge; returns at a negedge. Accept lands on the 5th edge after the drive.
  task automatic apply4(input vec_t v, input int idx);
    vec_t e;
    seg1a = v.s1;
    seg0a = v.s0;
    sb.push_back(v);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("u4[%0d] early update k=%0d", idx, k), 32'(upd4), 32'd0);
    end
    @(negedge clk);
    e = sb.pop_front();
    cmp_vec($sformatf("u4[%0d]", idx), e, val4, dp14, dp04, err4, upd4, ec4);
    @(negedge clk);
    chk($sformatf("u4[%0d] pulse width", idx), 32'(upd4), 32'd0);
  endtask

  task automatic apply1(input vec_t v, input string tag);
    vec_t e;
    seg1b = v.s1;
    seg0b = v.s0;
    sb.push_back(v);
    @(negedge clk);
    chk({tag, " early update"}, 32'(upd1), 32'd0);
    @(negedge clk);
    e = sb.pop_front();
    cmp_vec(tag, e, val1, dp11, dp01, err1, upd1, ec1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    //            s1     s0     val    dp1   dp0   err   upd   ec
    tbl[0]  = '{8'h14, 8'h73, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
    tbl[1]  = '{8'h14, 8'h7b, 8'h12, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{8'h14, 8'h01, 8'h12, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1};
    tbl[3]  = '{8'hf6, 8'he1, 8'h9f, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
    tbl[4]  = '{8'hd4, 8'he6, 8'h45, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
    tbl[5]  = '{8'h00, 8'hb7, 8'h45, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2};
    tbl[6]  = '{8'h57, 8'hcf, 8'hdb, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2};
    tbl[7]  = '{8'hf5, 8'ha3, 8'hac, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2};
    tbl[8]  = '{8'hbc, 8'hf7, 8'h78, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2};
    tbl[9]  = '{8'he3, 8'he7, 8'he6, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2};
    tbl[10] = '{8'h76, 8'hb6, 8'he6, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3};

    rst4 = 1'b1; rst1 = 1'b1;
    seg1a = 8'h00; seg0a = 8'h00;
    seg1b = 8'h14; seg0b = 8'h73;
    repeat (2) @(negedge clk);
    chk("reset value", 32'(val4), 32'h0);
    chk("reset error", 32'(err4), 32'h0);
    chk("reset update", 32'(upd4), 32'h0);
    chk("reset dp", 32'({dp14, dp04}), 32'h0);

    // 00/00 held through reset matches the cleared sample: invalid accept 4 edges after release.
    rst4 = 1'b0;
    repeat (3) @(negedge clk);
    chk("zero pattern not yet accepted", 32'(err4), 32'h0);
    @(negedge clk);
    chk("zero pattern error rises", 32'(err4), 32'h1);
`ifdef SEG7DEC_ERRCNT_EN
    chk("zero pattern errcnt", 32'(ec4), 32'h1);
`endif

    rst4 = 1'b1;
    @(negedge clk);
    chk("second reset error", 32'(err4), 32'h0);
`ifdef SEG7DEC_ERRCNT_EN
    chk("second reset errcnt", 32'(ec4), 32'h0);
`endif
    rst4 = 1'b0;
    @(negedge clk);

    apply4(tbl[0], 0);

    // Short glitch on the low digit, then back to the accepted pattern.
    seg0a = 8'hf7;
    repeat (2) @(negedge clk);
    seg0a = 8'h73;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("glitch update k=%0d", k), 32'(upd4), 32'h0);
      chk($sformatf("glitch value k=%0d", k), 32'(val4), 32'h12);
      chk($sformatf("glitch error k=%0d", k), 32'(err4), 32'h0);
    end

    for (int i = 1; i < 11; i++) apply4(tbl[i], i);

    // Reset lands while the counter sits at 2.
    seg1a = 8'h14; seg0a = 8'h73;
    repeat (3) @(negedge clk);
    rst4 = 1'b1;
    @(negedge clk);
    chk("midcount reset value", 32'(val4), 32'h0);
    chk("midcount reset error", 32'(err4), 32'h0);
    chk("midcount reset dp", 32'({dp14, dp04}), 32'h0);
    chk("midcount reset update", 32'(upd4), 32'h0);
`ifdef SEG7DEC_ERRCNT_EN
    chk("midcount reset errcnt", 32'(ec4), 32'h0);
`endif
    rst4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("post reset early update k=%0d", k), 32'(upd4), 32'h0);
    end
    @(negedge clk);
    chk("post reset update", 32'(upd4), 32'h1);
    chk("post reset value", 32'(val4), 32'h12);
    @(negedge clk);
    chk("post reset pulse width", 32'(upd4), 32'h0);

    // Single-cycle filter: every held pair is accepted on the second edge.
    rst1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) v = '{8'h14, 8'h73, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
      else            v = '{8'h76, 8'he6, 8'h35, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
      apply1(v, $sformatf("u1 alt[%0d]", i));
    end
    for (int i = 1; i <= 260; i++) begin
      if (i % 2 == 1) v = '{8'h01, 8'h01, 8'h35, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
      else            v = '{8'h02, 8'h02, 8'h35, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
      v.ec = (i > 255) ? 8'd255 : 8'(i);
      apply1(v, $sformatf("u1 bad[%0d]", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
